// File: rtl/dmem_if.sv
// LC-3b MEM-stage data-port bundle between the pipeline (master) and the
// data memory responder (slave).
interface dmem_if;
  // Handshake: the master raises mem_read or mem_write and holds it with
  // stable address/data until mem_resp is seen high for one cycle; the slave
  // samples a new request only in IDLE, and mem_resp is a single-cycle pulse.
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, proto_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, proto_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, programmable latency,
// byte-enabled word array. Define DMEM_STALL_INJECT_EN for LFSR extra latency.
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus_if,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CW = 5;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   we_q, we_d;
  logic [1:0]             be_q, be_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   perr_q, perr_d;
  logic                   commit;
  logic                   req;
  logic [CW-1:0]          lat_m1;

  logic [15:0] mem_q [2**ADDR_BITS];

  assign req = bus_if.mem_read | bus_if.mem_write;

`ifdef DMEM_STALL_INJECT_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign lat_m1 = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && req) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 4'b1001;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign lat_m1 = CW'(LATENCY - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = bus_if.mem_address[ADDR_BITS:1];
          we_d    = bus_if.mem_write;
          be_d    = bus_if.mem_byte_enable;
          wdata_d = bus_if.mem_wdata;
          cnt_d   = lat_m1;
          if (bus_if.mem_read && bus_if.mem_write) perr_d = 1'b1;
          if (lat_m1 == '0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The _d copies carry the live request on a LATENCY=1 accept, so commit
    // always uses them rather than the registered copies.
    if (commit && !we_d) rdata_d = mem_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Array is not cleared by reset; a write aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_d) begin
      if (be_d[0]) mem_q[idx_d][7:0]  <= wdata_d[7:0];
      if (be_d[1]) mem_q[idx_d][15:8] <= wdata_d[15:8];
    end
  end

  assign bus_if.mem_resp  = (state_q == RESP);
  assign bus_if.mem_rdata = rdata_q;
  assign bus_if.proto_err = perr_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one DUT at LATENCY=3, one at LATENCY=1,
// directed cases followed by randomized accesses against a word-array model.
module tb_dmem_responder;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_if if0 ();
  dmem_if if1 ();
  logic [1:0] dbg0, dbg1;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut0 (
    .clk(clk), .reset(reset), .bus_if(if0.slave), .dbg_state_o(dbg0));
  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus_if(if1.slave), .dbg_state_o(dbg1));

  logic        rd_s [2];
  logic        wr_s [2];
  logic [15:0] addr_s [2];
  logic [1:0]  be_s [2];
  logic [15:0] wd_s [2];

  assign if0.mem_read = rd_s[0];  assign if1.mem_read = rd_s[1];
  assign if0.mem_write = wr_s[0]; assign if1.mem_write = wr_s[1];
  assign if0.mem_address = addr_s[0]; assign if1.mem_address = addr_s[1];
  assign if0.mem_byte_enable = be_s[0]; assign if1.mem_byte_enable = be_s[1];
  assign if0.mem_wdata = wd_s[0]; assign if1.mem_wdata = wd_s[1];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain word arrays, last read value and sticky error.
  logic [15:0] mem_m [2][256];
  bit          wr_m  [2][256];
  logic [15:0] last_rd [2];
  bit          proto_m [2];
  logic [3:0]  lfsr_m  [2];

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  bit          prev_resp [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 16'h0000;
      proto_m[d] = 1'b0;
      lfsr_m[d]  = 4'b1001;
    end
  endtask

  task automatic mon_check(input int d, input logic [16:0] act);
    logic [16:0] exp;
    n_cmp++;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      n_err++;
      $display("FAIL mon%0d_unexpected_resp: got resp with proto=%0b rdata=%h, required no resp",
               d, act[16], act[15:0]);
    end else begin
      exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (act !== exp || prev_resp[d]) begin
        n_err++;
        $display("FAIL mon%0d_resp: got proto=%0b rdata=%h b2b=%0b, required proto=%0b rdata=%h b2b=0",
                 d, act[16], act[15:0], prev_resp[d], exp[16], exp[15:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (if0.mem_resp) mon_check(0, {if0.proto_err, if0.mem_rdata});
      if (if1.mem_resp) mon_check(1, {if1.proto_err, if1.mem_rdata});
    end
    prev_resp[0] = if0.mem_resp;
    prev_resp[1] = if1.mem_resp;
  end

  function automatic bit resp_of(input int d);
    return (d == 0) ? if0.mem_resp : if1.mem_resp;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called in an IDLE cycle (b2b=0) or in the RESP cycle of a held access (b2b=1).
  task automatic access(input int d, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] wd, input bit b2b, input bit hold);
    int lat, n;
    logic [7:0] idx;
    lat = (d == 0) ? 3 : 1;
`ifdef DMEM_STALL_INJECT_EN
    lat = lat + int'(lfsr_m[d][1:0]);
    lfsr_m[d] = {lfsr_m[d][2:0], lfsr_m[d][3] ^ lfsr_m[d][2]};
`endif
    rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = addr; be_s[d] = be; wd_s[d] = wd;
    idx = addr[8:1];
    if (wr) begin
      if (be[0]) mem_m[d][idx][7:0]  = wd[7:0];
      if (be[1]) mem_m[d][idx][15:8] = wd[15:8];
      wr_m[d][idx] = 1'b1;
    end else begin
      last_rd[d] = mem_m[d][idx];
    end
    if (rd && wr) proto_m[d] = 1'b1;
    if (d == 0) exp_q0.push_back({proto_m[d], last_rd[d]});
    else        exp_q1.push_back({proto_m[d], last_rd[d]});
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (resp_of(d)) break;
    end
    check($sformatf("latency_dut%0d_addr%h", d, addr), 32'(n), 32'(lat + (b2b ? 1 : 0)));
    if (!hold) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit prev_hold;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 0; wr_s[d] = 0; addr_s[d] = 0; be_s[d] = 0; wd_s[d] = 0;
      prev_resp[d] = 0;
    end
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_resp0", 32'(if0.mem_resp), 0);
    check("reset_rdata0", 32'(if0.mem_rdata), 0);
    check("reset_perr0", 32'(if0.proto_err), 0);
    check("reset_resp1", 32'(if1.mem_resp), 0);
    check("reset_rdata1", 32'(if1.mem_rdata), 0);
    @(posedge clk); #1;

    // Basic write then read
    access(0, 0, 1, 16'h0010, 2'b11, 16'hBEEF, 0, 0);
    access(0, 1, 0, 16'h0010, 2'b00, 16'h0000, 0, 0);
    // Byte lanes, then a no-lane write
    access(0, 0, 1, 16'h0020, 2'b11, 16'h1234, 0, 0);
    access(0, 0, 1, 16'h0020, 2'b10, 16'hAB00, 0, 0);
    access(0, 0, 1, 16'h0020, 2'b01, 16'h00CD, 0, 0);
    access(0, 1, 0, 16'h0020, 2'b00, 16'h0000, 0, 0);
    access(0, 0, 1, 16'h0020, 2'b00, 16'hFFFF, 0, 0);
    access(0, 1, 0, 16'h0020, 2'b00, 16'h0000, 0, 0);
    // LDI-style double read with the request held across the first resp
    access(0, 0, 1, 16'h0040, 2'b11, 16'h4040, 0, 0);
    access(0, 0, 1, 16'h0042, 2'b11, 16'h4242, 0, 0);
    access(0, 1, 0, 16'h0040, 2'b00, 16'h0000, 0, 1);
    access(0, 1, 0, 16'h0042, 2'b00, 16'h0000, 1, 0);
    // Simultaneous read and write
    access(0, 1, 1, 16'h0008, 2'b11, 16'h5555, 0, 0);
    access(0, 1, 0, 16'h0008, 2'b00, 16'h0000, 0, 0);
    check("perr_sticky", 32'(if0.proto_err), 1);

    // Reset during BUSY of a write
    access(0, 0, 1, 16'h0030, 2'b11, 16'h1111, 0, 0);
    rd_s[0] = 0; wr_s[0] = 1; addr_s[0] = 16'h0030; be_s[0] = 2'b11; wd_s[0] = 16'h7777;
    @(posedge clk); #1;
    reset = 1'b1; wr_s[0] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("midreset_resp", 32'(if0.mem_resp), 0);
    check("midreset_rdata", 32'(if0.mem_rdata), 0);
    check("midreset_perr", 32'(if0.proto_err), 0);
    repeat (6) @(posedge clk); #1;
    access(0, 1, 0, 16'h0030, 2'b00, 16'h0000, 0, 0);

    // LATENCY=1 and aliasing
    access(1, 0, 1, 16'h0202, 2'b11, 16'hCAFE, 0, 0);
    access(1, 1, 0, 16'h0002, 2'b00, 16'h0000, 0, 0);
    access(1, 0, 1, 16'hFFFE, 2'b11, 16'h0FFE, 0, 1);
    access(1, 1, 0, 16'h01FE, 2'b00, 16'h0000, 1, 0);

    // Randomized accesses on both instances
    for (int d = 0; d < 2; d++) begin
      prev_hold = 0;
      for (int i = 0; i < 50; i++) begin
        logic [7:0] idx;
        logic [15:0] addr;
        bit rd, wr, hold;
        idx  = 8'($urandom_range(0, 15));
        addr = {7'($urandom_range(0, 127)), idx, 1'b0};
        if (!wr_m[d][idx] || $urandom_range(0, 1) == 1) begin
          wr = 1; rd = ($urandom_range(0, 7) == 0);
        end else begin
          wr = 0; rd = 1;
        end
        hold = (i != 49) && ($urandom_range(0, 2) == 0);
        access(d, rd, wr, addr, 2'($urandom_range(0, 3)), 16'($urandom), prev_hold, hold);
        prev_hold = hold;
      end
    end

    repeat (5) @(posedge clk); #1;
    check("leftover_q0", 32'(exp_q0.size()), 0);
    check("leftover_q1", 32'(exp_q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
